// File: rtl/ex_pkg.sv
// ============================================================================
// ex_pkg : op codes, FSM encodings and forwarding helper for the execute stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIVU = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    // x0 is hard-wired zero, so a write to it must never be forwarded
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter : XLEN-step shift-add multiplier / restoring unsigned divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    // MUL: acc=product, quo=multiplier, dvsr=multiplicand
    // DIV: acc=remainder, quo=dividend shifting into quotient, dvsr=divisor
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    assign w_rem_sh = {r_acc, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
    assign w_fits   = ~w_diff[XLEN];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_op    <= '0;
            r_acc   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
        end else if (start) begin
            r_count <= '0;
            r_busy  <= 1'b1;
            r_op    <= op;
            r_acc   <= '0;
            r_quo   <= (op == ALU_MUL) ? b : a;
            r_dvsr  <= (op == ALU_MUL) ? a : b;
        end else if (r_busy) begin
            r_count <= r_count + CW'(1);
            if (r_count == CW'(XLEN-1))
                r_busy <= 1'b0;
            if (r_op == ALU_MUL) begin
                if (r_quo[0])
                    r_acc <= r_acc + r_dvsr;
                r_quo  <= r_quo >> 1;
                r_dvsr <= r_dvsr << 1;
            end else if (w_fits) begin
                r_acc <= w_diff[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_acc <= {r_acc[XLEN-2:0], r_quo[XLEN-1]};
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_busy && (r_count == CW'(XLEN-1));
    assign result = (r_op == ALU_DIVU) ? r_quo : r_acc;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : RV32 execute stage with forwarding, ALU and iterative MUL/DIVU/REMU
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] reg1_in,
    input  logic [XLEN-1:0] reg2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [3:0]      alu_ctrl_in,
    input  logic            alu_src_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic            mem_to_reg_in,
    input  logic [4:0]      exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_data,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            reg_write_out,
    output logic            mem_to_reg_out,
    output logic            stall_out
);

    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu;
    logic [4:0]      w_shamt;
    logic [3:0]      w_ctrl_in;
    logic            w_multi;

    logic [1:0]      r_state, w_state_nxt;
    logic            w_stall, w_md_start, w_bubble, w_load_md;
    logic            w_md_busy, w_md_done;
    logic [XLEN-1:0] w_md_result;

    logic [XLEN-1:0] r_lat_pc, r_lat_st;
    logic [4:0]      r_lat_rd;
    logic [3:0]      r_lat_ctrl;

    logic [XLEN-1:0] r_result, r_store, r_pc;
    logic [4:0]      r_rd;
    logic [3:0]      r_ctrl;

    always_comb begin
        w_fwd_a = reg1_in;
        if (fwd_hit(exm_reg_write, exm_rd, rs1_in))
            w_fwd_a = exm_result;
        else if (fwd_hit(mwb_reg_write, mwb_rd, rs1_in))
            w_fwd_a = mwb_data;
    end

    always_comb begin
        w_fwd_b = reg2_in;
        if (fwd_hit(exm_reg_write, exm_rd, rs2_in))
            w_fwd_b = exm_result;
        else if (fwd_hit(mwb_reg_write, mwb_rd, rs2_in))
            w_fwd_b = mwb_data;
    end

    assign w_op_b    = alu_src_in ? imm_in : w_fwd_b;
    assign w_shamt   = w_op_b[4:0];
    assign w_multi   = is_multi(alu_ctrl_in);
    assign w_ctrl_in = {mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in};

    always_comb begin
        w_alu = '0;
        case (alu_ctrl_in)
            ALU_ADD:  w_alu = w_fwd_a + w_op_b;
            ALU_SUB:  w_alu = w_fwd_a - w_op_b;
            ALU_AND:  w_alu = w_fwd_a & w_op_b;
            ALU_OR:   w_alu = w_fwd_a | w_op_b;
            ALU_XOR:  w_alu = w_fwd_a ^ w_op_b;
            ALU_SLL:  w_alu = w_fwd_a << w_shamt;
            ALU_SRL:  w_alu = w_fwd_a >> w_shamt;
            ALU_SRA:  w_alu = $signed(w_fwd_a) >>> w_shamt;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_fwd_a < w_op_b)};
            default:  w_alu = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_md_start),
        .op      (alu_ctrl_in),
        .a       (w_fwd_a),
        .b       (w_op_b),
        .busy    (w_md_busy),
        .done    (w_md_done),
        .result  (w_md_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_multi) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (w_md_done)
                    w_state_nxt = ST_DONE;
                else if (!w_md_busy)
                    w_state_nxt = ST_IDLE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall    = 1'b0;
        w_md_start = 1'b0;
        w_bubble   = 1'b0;
        w_load_md  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall    = w_multi;
                w_md_start = w_multi;
                w_bubble   = w_multi;
            end
            ST_BUSY: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            ST_DONE: w_load_md = 1'b1;
            default: w_bubble = 1'b1;
        endcase
    end

    // Gated so the stall releases the instant reset asserts, whatever sits in ID/EX
    assign stall_out = w_stall & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_pc   <= '0;
            r_lat_st   <= '0;
            r_lat_rd   <= '0;
            r_lat_ctrl <= '0;
        end else if (w_md_start) begin
            r_lat_pc   <= pc_in;
            r_lat_st   <= w_fwd_b;
            r_lat_rd   <= rd_in;
            r_lat_ctrl <= w_ctrl_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || w_bubble) begin
            r_result <= '0;
            r_store  <= '0;
            r_pc     <= '0;
            r_rd     <= '0;
            r_ctrl   <= '0;
        end else if (w_load_md) begin
            r_result <= w_md_result;
            r_store  <= r_lat_st;
            r_pc     <= r_lat_pc;
            r_rd     <= r_lat_rd;
            r_ctrl   <= r_lat_ctrl;
        end else begin
            r_result <= w_alu;
            r_store  <= w_fwd_b;
            r_pc     <= pc_in;
            r_rd     <= rd_in;
            r_ctrl   <= w_ctrl_in;
        end
    end

    assign alu_result_out = r_result;
    assign store_data_out = r_store;
    assign pc_out         = r_pc;
    assign rd_out         = r_rd;
    assign {mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out} = r_ctrl;

endmodule

`default_nettype wire
